// File: rtl/tone_pkg.sv
// Shared types and helpers for the tone detector and its benches.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_NO_SIGNAL = 2'd0,
        ST_ARMED     = 2'd1,
        ST_ACQUIRE   = 2'd2,
        ST_LOCKED    = 2'd3
    } tone_state_t;

    // Expected tone period for a buzzer note divider (divider toggles the pin).
    function automatic int unsigned note_period(input int unsigned div);
        return 2 * div;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus history flop; flags a rising edge of an async input.
module sync_edge_detect (
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;

endmodule

// File: rtl/tone_detector.sv
// Measures the rising-edge period of a square wave, declares lock when stable
// and flags loss of signal on timeout.
//
//   state        | meaning
//   -------------+-------------------------------------------
//   ST_NO_SIGNAL | reset / timed out, waiting for a first edge
//   ST_ARMED     | one edge seen, no period yet
//   ST_ACQUIRE   | periods measured, lock not reached
//   ST_LOCKED    | LOCK_COUNT consecutive matching periods
module tone_detector
    import tone_pkg::*;
#(
    parameter int PERIOD_WIDTH = 24,
    parameter int MAX_PERIOD   = 2**24 - 1,
    parameter int TOLERANCE    = 2,
    parameter int LOCK_COUNT   = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    wave_in,
    output logic [PERIOD_WIDTH-1:0] period_out,
    output logic                    period_valid,
    output logic                    locked,
    output logic                    no_signal
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX    = PERIOD_WIDTH'(MAX_PERIOD);
    localparam logic [PERIOD_WIDTH:0]   TOL        = (PERIOD_WIDTH + 1)'(TOLERANCE);
    localparam logic [MATCH_W-1:0]      MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);

    tone_state_t             state;
    logic                    rise;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] p_prev;
    logic [MATCH_W-1:0]      match_cnt;
    logic [PERIOD_WIDTH:0]   cnt_ext;
    logic [PERIOD_WIDTH:0]   prev_ext;
    logic [PERIOD_WIDTH:0]   diff;
    logic                    match;
    logic                    timeout;

    sync_edge_detect u_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .async_in (wave_in),
        .rise     (rise)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= PERIOD_WIDTH'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + PERIOD_WIDTH'(1);
        end
    end

    // One extra bit keeps the absolute difference from wrapping.
    assign cnt_ext  = {1'b0, cnt};
    assign prev_ext = {1'b0, p_prev};
    assign diff     = (cnt_ext >= prev_ext) ? (cnt_ext - prev_ext) : (prev_ext - cnt_ext);
    assign match    = (diff <= TOL);
    assign timeout  = (state != ST_NO_SIGNAL) && (cnt == CNT_MAX);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= ST_NO_SIGNAL;
            period_out   <= '0;
            p_prev       <= '0;
            period_valid <= 1'b0;
            match_cnt    <= '0;
            locked       <= 1'b0;
            no_signal    <= 1'b1;
        end else begin
            period_valid <= 1'b0;
            if (rise) begin
                if (state != ST_NO_SIGNAL) begin
                    period_out   <= cnt;
                    p_prev       <= cnt;
                    period_valid <= 1'b1;
                end
                case (state)
                    ST_NO_SIGNAL: begin
                        state     <= ST_ARMED;
                        no_signal <= 1'b0;
                    end
                    ST_ARMED: begin
                        state     <= ST_ACQUIRE;
                        match_cnt <= '0;
                    end
                    ST_ACQUIRE: begin
                        if (!match) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MATCH_LAST) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end else begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (!match) begin
                            state     <= ST_ACQUIRE;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                        end
                    end
                    default: begin
                        state <= ST_NO_SIGNAL;
                    end
                endcase
            end else if (timeout) begin
                // A rise in the same cycle takes priority; see the branch above.
                state     <= ST_NO_SIGNAL;
                locked    <= 1'b0;
                no_signal <= 1'b1;
                match_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tone_detector.sv
// Randomized bench for tone_detector against a period/run-length reference model.
module tb_tone_detector;
    import tone_pkg::*;

    localparam int PW   = 24;
    localparam int MAXP = 50;
    localparam int TOL  = 2;
    localparam int LC   = 4;

    logic          clk_in  = 1'b0;
    logic          rst_in  = 1'b1;
    logic          wave_in = 1'b0;
    logic [PW-1:0] period_out;
    logic          period_valid;
    logic          locked;
    logic          no_signal;

    tone_detector #(
        .PERIOD_WIDTH (PW),
        .MAX_PERIOD   (MAXP),
        .TOLERANCE    (TOL),
        .LOCK_COUNT   (LC)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .wave_in      (wave_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked),
        .no_signal    (no_signal)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: edge-indexed arithmetic on sampled input history.
    int cyc         = 0;
    int last_ref    = 1;
    bit w1          = 0;
    bit w2          = 0;
    bit w3          = 0;
    bit have_signal = 0;
    bit have_period = 0;
    int prev_p      = 0;
    int run_len     = 0;
    int exp_period  = 0;
    bit exp_valid   = 0;

    int dut_pulses  = 0;
    int lock_base   = 0;
    int lock_pulse  = -1;

    task automatic model_step(input bit w, input bit r);
        int elapsed;
        int d;
        bit is_rise;
        if (r) begin
            w1 = 0; w2 = 0; w3 = 0;
            have_signal = 0; have_period = 0; run_len = 0;
            exp_period = 0; exp_valid = 0;
            last_ref = cyc + 1;
            return;
        end
        is_rise = w2 && !w3;
        elapsed = cyc - last_ref;
        if (elapsed > MAXP) elapsed = MAXP;
        exp_valid = 0;
        if (is_rise) begin
            if (have_signal) begin
                if (have_period) begin
                    d = elapsed - prev_p;
                    if (d < 0) d = -d;
                    run_len = (d <= TOL) ? run_len + 1 : 0;
                end else begin
                    run_len = 0;
                end
                have_period = 1;
                prev_p      = elapsed;
                exp_period  = elapsed;
                exp_valid   = 1;
            end else begin
                have_signal = 1;
                have_period = 0;
                run_len     = 0;
            end
            last_ref = cyc;
        end else if (have_signal && elapsed == MAXP) begin
            have_signal = 0;
            have_period = 0;
            run_len     = 0;
        end
        w3 = w2;
        w2 = w1;
        w1 = w;
    endtask

    task automatic tick(input bit w, input bit r);
        @(negedge clk_in);
        wave_in = w;
        rst_in  = r;
        @(posedge clk_in);
        cyc++;
        model_step(w, r);
        #1;
        if (period_valid === 1'b1) dut_pulses++;
        if (locked === 1'b1 && lock_pulse < 0) lock_pulse = dut_pulses - lock_base;
        chk_eq("period_valid", period_valid, exp_valid);
        chk_eq("period_out", period_out, exp_period);
        chk_eq("locked", locked, (have_signal && have_period && run_len >= LC) ? 1 : 0);
        chk_eq("no_signal", no_signal, have_signal ? 0 : 1);
    endtask

    task automatic drive_period(input int p, input int hi);
        repeat (hi) tick(1'b1, 1'b0);
        repeat (p - hi) tick(1'b0, 1'b0);
    endtask

    initial begin
        int base;
        int p;
        int bp;
        int jit [5] = '{8, 9, 7, 8, 10};

        // Reset and static input
        repeat (3) tick(1'b0, 1'b1);
        chk_eq("rst_period_out", period_out, 0);
        chk_eq("rst_period_valid", period_valid, 0);
        chk_eq("rst_locked", locked, 0);
        chk_eq("rst_no_signal", no_signal, 1);
        base = dut_pulses;
        repeat (100) tick(1'b0, 1'b0);
        chk_eq("idle_pulses", dut_pulses - base, 0);

        // Stable period 8: first edge arms, second edge gives the first pulse 3 edges later
        lock_base  = dut_pulses;
        lock_pulse = -1;
        drive_period(8, 4);
        repeat (3) tick(1'b1, 1'b0);
        chk_eq("first_pulse_valid", period_valid, 1);
        chk_eq("first_pulse_period", period_out, 8);
        tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        repeat (6) drive_period(8, 4);
        chk_eq("lock_on_pulse", lock_pulse, LC + 1);

        // Jitter within tolerance, then a step, then relock
        foreach (jit[i]) drive_period(jit[i], jit[i] / 2);
        chk_eq("jitter_locked", locked, 1);
        repeat (6) drive_period(13, 6);
        chk_eq("relock", locked, 1);

        // Timeout while locked, then resume
        repeat (60) tick(1'b0, 1'b0);
        chk_eq("timeout_no_signal", no_signal, 1);
        chk_eq("timeout_locked", locked, 0);
        chk_eq("timeout_period_held", period_out, 13);
        base = dut_pulses;
        drive_period(8, 4);
        chk_eq("resume_arm_only", dut_pulses - base, 0);
        repeat (6) drive_period(8, 4);

        // Rise coinciding with cnt == MAX_PERIOD
        drive_period(MAXP, MAXP / 2);
        repeat (3) tick(1'b1, 1'b0);
        chk_eq("max_valid", period_valid, 1);
        chk_eq("max_period", period_out, MAXP);
        chk_eq("max_no_signal", no_signal, 0);
        tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);

        // Loopback from a buzzer divider of 2
        repeat (10) drive_period(note_period(2), 2);
        chk_eq("loop_period", period_out, note_period(2));
        chk_eq("loop_locked", locked, 1);

        // Reset mid-lock with the input held high
        tick(1'b1, 1'b1);
        chk_eq("midrst_period_out", period_out, 0);
        chk_eq("midrst_valid", period_valid, 0);
        chk_eq("midrst_locked", locked, 0);
        chk_eq("midrst_no_signal", no_signal, 1);
        repeat (3) tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        repeat (6) drive_period(6, 3);

        // Randomized periods, jitter, idles and resets
        bp = 10;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0) bp = $urandom_range(3, 20);
            p = bp + $urandom_range(0, 6) - 3;
            if (p < 2) p = 2;
            drive_period(p, $urandom_range(1, p - 1));
            if ($urandom_range(0, 24) == 0) repeat ($urandom_range(40, 60)) tick(1'b0, 1'b0);
            if ($urandom_range(0, 49) == 0) tick($urandom_range(0, 1) == 1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
